// File: rtl/mips_cpu_multdiv_if.sv
// Operand, control and result bundle between decode and mult/div unit.
// master = CPU decode side, slave = mips_cpu_multdiv.
interface mips_cpu_multdiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        write_hi;
  logic        write_lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, write_hi, write_lo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, write_hi, write_lo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_multdiv.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO.
// Option: MIPS_CPU_MULTDIV_FAST_MULT_EN gives single-cycle multiplies.
module mips_cpu_multdiv (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  mips_cpu_multdiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] araw_q, araw_d;
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dzf_q, dzf_d;

  logic        sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        b_zero;
  logic        calc_last;
  logic [32:0] msum;
  logic [32:0] dtop;
  logic [32:0] ddif;
  logic [63:0] prod;

  assign sgn    = bus.op[0];
  assign a_abs  = (sgn && bus.a[31]) ? -bus.a : bus.a;
  assign b_abs  = (sgn && bus.b[31]) ? -bus.b : bus.b;
  assign b_zero = (bus.b == 32'd0);

`ifdef MIPS_CPU_MULTDIV_FAST_MULT_EN
  assign calc_last = !op_q[1] || (cnt_q == 6'd31);
`else
  assign calc_last = (cnt_q == 6'd31);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (clk_enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.op[1] && b_zero) ? FIX : CALC;
        end
      end
      CALC: begin
        if (calc_last) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and result registers
  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.done        = done_q;
    bus.div_by_zero = dzf_q;
    bus.hi          = hi_q;
    bus.lo          = lo_q;
  end

  // Datapath: operand capture, iteration step, sign fix-up, MTHI/MTLO
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    araw_d = araw_q;
    op_d   = op_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dzf_d  = dzf_q;
    done_d = (state_q == FIX);
    msum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    dtop   = acc_q[63:31];
    ddif   = dtop - {1'b0, dvs_q};
    prod   = neg_q ? -acc_q : acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          acc_d  = {32'd0, bus.op[1] ? a_abs : b_abs};
          dvs_d  = bus.op[1] ? b_abs : a_abs;
          neg_d  = sgn && (bus.a[31] ^ bus.b[31]);
          rneg_d = sgn && bus.a[31];
          dz_d   = bus.op[1] && b_zero;
          araw_d = bus.a;
          cnt_d  = 6'd0;
          dzf_d  = 1'b0;
        end else begin
          if (bus.write_hi) hi_d = bus.a;
          if (bus.write_lo) lo_d = bus.a;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[1]) begin
          if (!ddif[32]) begin
            acc_d = {ddif[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {dtop[31:0], acc_q[30:0], 1'b0};
          end
        end else begin
`ifdef MIPS_CPU_MULTDIV_FAST_MULT_EN
          acc_d = {32'd0, dvs_q} * {32'd0, acc_q[31:0]};
`else
          acc_d = {msum, acc_q[31:1]};
`endif
        end
      end
      FIX: begin
        if (dz_q) begin
          hi_d  = araw_q;
          lo_d  = 32'hFFFF_FFFF;
          dzf_d = 1'b1;
        end else if (op_q[1]) begin
          lo_d = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
          hi_d = rneg_q ? -acc_q[63:32] : acc_q[63:32];
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 6'd0;
      acc_q  <= 64'd0;
      dvs_q  <= 32'd0;
      araw_q <= 32'd0;
      op_q   <= 2'd0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
      dzf_q  <= 1'b0;
    end else if (clk_enable) begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      araw_q <= araw_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dzf_q  <= dzf_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Bench for mips_cpu_multdiv: directed table, random ops vs
// arithmetic model, and hand-written multi-cycle sequences.
module tb_mips_cpu_multdiv;

  logic clk;
  logic reset;
  logic clk_enable;
  int   total;
  int   bad;

  mips_cpu_multdiv_if bus ();

  mips_cpu_multdiv dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    model = '0;
    case (op)
      2'b00: begin
        p = {32'd0, a} * {32'd0, b};
        model = {1'b0, p};
      end
      2'b01: begin
        p = sa * sb;
        model = {1'b0, p};
      end
      default: begin
        if (b == 32'd0) begin
          model = {1'b1, a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          model = {1'b0, a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          model = {1'b0, r[31:0], q[31:0]};
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op,
                                 input logic [31:0] b);
    if (op[1] && b == 32'd0) return 2;
`ifdef MIPS_CPU_MULTDIV_FAST_MULT_EN
    if (!op[1]) return 3;
`endif
    return 34;
  endfunction

  // Caller is at a negedge; start is driven immediately.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit pulse_chk,
                       output logic [31:0] rhi, output logic [31:0] rlo,
                       output logic rdz, output int lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat = 1;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rhi = bus.hi;
    rlo = bus.lo;
    rdz = bus.div_by_zero;
    chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
    if (pulse_chk) begin
      @(negedge clk);
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    end
  endtask

  task automatic run_chk(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input bit pulse_chk);
    logic [31:0] rhi;
    logic [31:0] rlo;
    logic        rdz;
    int          lat;
    do_op(op, a, b, pulse_chk, rhi, rlo, rdz, lat);
    chk({tag, "_hi"}, rhi, ehi);
    chk({tag, "_lo"}, rlo, elo);
    chk({tag, "_dz"}, {31'd0, rdz}, {31'd0, edz});
    chk({tag, "_lat"}, lat, exp_lat(op, b));
  endtask

  initial begin
    logic [64:0] m;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] h0;
    logic [31:0] l0;
    int          lat;
    int          ndone;

    total = 0;
    bad   = 0;

    vt[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vt[1] = '{2'b01, 32'hFFFF_FFF9, 32'd3,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vt[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[3] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vt[4] = '{2'b11, 32'h1234_5678, 32'd0,
              32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    vt[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, 1'b0};
    vt[6] = '{2'b01, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'd0, 1'b0};
    vt[7] = '{2'b10, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0};
    vt[8] = '{2'b11, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, 1'b0};
    vt[9] = '{2'b10, 32'h0000_0005, 32'd0,
              32'h0000_0005, 32'hFFFF_FFFF, 1'b1};

    reset      = 1'b1;
    clk_enable = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.write_hi = 1'b0;
    bus.write_lo = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_chk($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
              vt[i].hi, vt[i].lo, vt[i].dz, 1'b1);
    end

    // div_by_zero holds across MTLO, clears on next accepted start
    bus.write_lo = 1'b1;
    bus.a        = 32'hCAFE_F00D;
    @(negedge clk);
    bus.write_lo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'hCAFE_F00D);
    chk("dz_hold", {31'd0, bus.div_by_zero}, 32'd1);
    chk("mtlo_no_done", {31'd0, bus.done}, 32'd0);
    bus.write_hi = 1'b1;
    bus.a        = 32'h0BAD_BEEF;
    @(negedge clk);
    bus.write_hi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h0BAD_BEEF);
    h0 = bus.hi;
    l0 = bus.lo;

    // start wins over write_lo; write_hi and start ignored while busy
    bus.start    = 1'b1;
    bus.write_lo = 1'b1;
    bus.op       = 2'b00;
    bus.a        = 32'd3;
    bus.b        = 32'd5;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.write_lo = 1'b0;
    chk("dz_cleared", {31'd0, bus.div_by_zero}, 32'd0);
    chk("start_wins_lo", bus.lo, l0);
    bus.write_hi = 1'b1;
    bus.a        = 32'h5555_AAAA;
    @(negedge clk);
    bus.write_hi = 1'b0;
    chk("mthi_busy_hi", bus.hi, h0);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd99;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ign_lat", lat, exp_lat(2'b00, 32'd5));
    chk("busy_ign_hi", bus.hi, 32'd0);
    chk("busy_ign_lo", bus.lo, 32'd15);
    chk("busy_ign_dz", {31'd0, bus.div_by_zero}, 32'd0);

    // back-to-back: next start in the done cycle
    run_chk("b2b_first", 2'b10, 32'd1000, 32'd33,
            32'd10, 32'd30, 1'b0, 1'b0);
    run_chk("b2b_second", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
            32'd0, 32'd6, 1'b0, 1'b1);

    // clk_enable freezes iteration and stretches done
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd81;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    clk_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("ce_busy", {31'd0, bus.busy}, 32'd1);
    chk("ce_hi", bus.hi, 32'd0);
    clk_enable = 1'b1;
    lat = 9;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("ce_lat", lat, 38);
    chk("ce_lo", bus.lo, 32'd9);
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("ce_done_stretch", {31'd0, bus.done}, 32'd1);
    clk_enable = 1'b1;
    @(negedge clk);
    chk("ce_done_drop", {31'd0, bus.done}, 32'd0);

    // reset at iteration 10 aborts with no done
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd1234;
    bus.b     = 32'd4321;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // random operations vs arithmetic model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 16));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      m = model(rop, ra, rb);
      run_chk($sformatf("rnd%0d", i), rop, ra, rb,
              m[63:32], m[31:0], m[64], 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_multdiv.md
# mips_cpu_multdiv

Iterative multiply/divide unit that executes MULT, MULTU, DIV and DIVU for `mips_cpu_harvard`. The CPU decode stage issues operands (rs, rt) with a start pulse and stalls on `busy`. The unit owns the architectural HI/LO registers, which also serve MFHI/MFLO reads and MTHI/MTLO writes. It replaces the combinational `*`, `/` and `%` operators with a synthesisable shift-add multiplier and a restoring divider.

## Interface
Parameters:
- None. The datapath is fixed at 32-bit operands and 64-bit HI:LO.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_enable`  in  1  when low, all state is frozen, outputs included.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  32  rs operand and dividend; also the MTHI/MTLO write data.
- `b`  in  32  rt operand and divisor.
- `write_hi`, `write_lo`  in  1 each  MTHI/MTLO: load `a` into `hi`/`lo`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `div_by_zero`  out  1  flags a divide with `b`==0; valid with `done`.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- IDLE
  - On `start`: latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Record the result signs and clear the 6-bit iteration counter.
  - Go to CALC, or to FIX for a divide with `b`==0.
- CALC, multiply: one shift-add step per cycle on a 64-bit accumulator.
- CALC, divide: one restoring step per cycle: shift, trial subtract, set quotient bit.
- CALC lasts 32 cycles, then goes to FIX.
- FIX
  - Apply two's-complement sign correction.
  - Product is negative if the operand signs differ (signed ops only).
  - Quotient is negative if the operand signs differ; the remainder takes the sign of the dividend.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Result mapping:
  - Multiply: `hi` = product[63:32], `lo` = product[31:0].
  - Divide: `lo` = quotient, `hi` = remainder.
- Divide by zero: `hi` = `a`, `lo` = 32'hFFFFFFFF, `div_by_zero` = 1.
- Overflow cases:
  - DIV of 32'h80000000 by 32'hFFFFFFFF: `lo` = 32'h80000000, `hi` = 0 (wraps naturally).
  - MULT of 32'h80000000 by 32'h80000000: `hi` = 32'h40000000, `lo` = 0.
- `write_hi`/`write_lo`
  - Act only in IDLE and only when `start` is low; `start` wins a same-cycle conflict.
  - Ignored while `busy`.
  - Do not pulse `done`.
- `start` while `busy` is ignored and not queued.
- Operands are captured on the accepting edge, so later changes to `a`/`b` have no effect.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `hi`, `lo` = 0.
- Reset mid-operation aborts at the next edge and gives the same values; no `done` is produced.
- Latency, start accepted at edge E0:
  - `busy` = 1 after E0.
  - CALC iterations occur at E1..E32.
  - FIX at E33 updates `hi`/`lo`; `done` = 1 and `busy` = 0 for the cycle after E33.
- Divide by zero: FIX at E1; `done` is high for the cycle after E1.
- `busy` is combinationally equal to (state != IDLE) and is registered through the state.
- Back-to-back: a `start` in the cycle where `done` is high is accepted, since the state is already IDLE.
- `div_by_zero` holds until the next accepted `start` clears it.
- `clk_enable` low:
  - Freezes the state, counter, `hi`/`lo` and `done`.
  - A pending `done` pulse stretches until `clk_enable` returns high for one edge.
- `hi`/`lo` change only on a FIX edge, an accepted MTHI/MTLO, or reset.

## Configuration
- `MIPS_CPU_MULTDIV_FAST_MULT_EN` defined:
  - Multiplies use a single-cycle combinational 32x32 product, and CALC lasts 1 cycle.
  - MULT/MULTU `done` is high in the cycle after E2.
  - Divides are unchanged.
- `MIPS_CPU_MULTDIV_FAST_MULT_EN` undefined: all operations use the 32-iteration path described above.

## Test plan
- MULTU, `a`=32'hFFFFFFFF, `b`=32'hFFFFFFFF -> after 34 cycles, `hi`=32'hFFFFFFFE and `lo`=32'h00000001 with `done` pulsed once.
- MULT, `a`=-7 (32'hFFFFFFF9), `b`=3 -> `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB.
- DIV, `a`=-7, `b`=2 -> `lo`=32'hFFFFFFFD (-3), `hi`=32'hFFFFFFFF (-1). DIVU, `a`=100, `b`=7 -> `lo`=14, `hi`=2.
- DIV by `b`=0 with `a`=32'h12345678 -> `done` after 2 cycles, `hi`=32'h12345678, `lo`=32'hFFFFFFFF, `div_by_zero`=1.
- Ignored inputs:
  - `start` while `busy` -> ignored, and the first result is unaffected.
  - `write_hi` while `busy` -> `hi` unchanged.
  - `write_lo` in IDLE with `a`=32'hCAFEF00D -> `lo`=32'hCAFEF00D next cycle.
- `reset` asserted at iteration 10 -> next cycle `busy`=0, `hi`=`lo`=0, and no `done` pulse follows.
